// File: rtl/dlfloat_mac_ctrl_if.sv
// Host/MAC bundle for the DLFloat16 MAC job sequencer.
// slave modport: the sequencer; master modport: host and MAC side.
//
// Handshakes: a transfer happens on a rising clk edge where both valid
// and ready are high. Valid may only drop after that transfer, and the
// payload stays stable while valid waits for ready.
interface dlfloat_mac_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic             mac_clr;
    logic [15:0]      mac_acc;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             err;

    modport slave (
        input  start, len, op_valid, op_a, op_b, mac_acc, res_ready,
        output busy, op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, err
    );

    modport master (
        output start, len, op_valid, op_a, op_b, mac_acc, res_ready,
        input  busy, op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, err
    );
endinterface

// File: rtl/dlfloat_mac_ctrl.sv
// Job sequencer for the DLFloat16 MAC: clears the accumulator, streams
// len operand pairs into the MAC, waits out the MAC pipeline and holds
// the captured sum (plus a sticky NaN flag) on the result port.
// Optional feature macro: DLMAC_CTRL_ABORT_EN adds an abort input that
// cancels a running job and clears the accumulator.
// state_dbg exposes the FSM state for checkers.
module dlfloat_mac_ctrl #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DLMAC_CTRL_ABORT_EN
    input  logic                 abort,
`endif
    dlfloat_mac_ctrl_if.slave    bus,
    output logic [2:0]           state_dbg
);
    localparam int          DRN_W   = $clog2(PIPE_LAT + 2);
    localparam logic [15:0] NAN_PAT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pair_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic             abort_req;
    logic             job_active;

`ifdef DLMAC_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign job_active = (state == S_CLEAR) || (state == S_FEED) || (state == S_DRAIN);
    assign state_dbg  = state;

    // Job FSM; every output is a register so the MAC sees clean operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            len_q         <= '0;
            pair_cnt      <= '0;
            drain_cnt     <= '0;
            bus.busy      <= 1'b0;
            bus.op_ready  <= 1'b0;
            bus.mac_a     <= '0;
            bus.mac_b     <= '0;
            bus.mac_clr   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.err       <= 1'b0;
        end else begin
            // Operands default to a zero bubble so the adder passes the
            // accumulator through on every cycle without a fresh pair.
            bus.mac_clr <= 1'b0;
            bus.mac_a   <= '0;
            bus.mac_b   <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len_q    <= bus.len;
                        pair_cnt <= '0;
                        bus.err  <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.len == '0) begin
                            bus.res_data  <= '0;
                            bus.res_valid <= 1'b1;
                            state         <= S_RESULT;
                        end else begin
                            bus.mac_clr <= 1'b1;
                            state       <= S_CLEAR;
                        end
                    end
                end
                S_CLEAR: begin
                    bus.op_ready <= 1'b1;
                    state        <= S_FEED;
                end
                S_FEED: begin
                    if (bus.op_valid && bus.op_ready) begin
                        bus.mac_a <= bus.op_a;
                        bus.mac_b <= bus.op_b;
                        pair_cnt  <= pair_cnt + 1'b1;
                        if (bus.op_a == NAN_PAT || bus.op_b == NAN_PAT) begin
                            bus.err <= 1'b1;
                        end
                        // Terminal compare on the pre-increment count, so
                        // the counter never has to hold more than len.
                        if (pair_cnt == len_q - 1'b1) begin
                            bus.op_ready <= 1'b0;
                            drain_cnt    <= '0;
                            state        <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // PIPE_LAT+1 cycles: last pair through multiplier and
                    // accumulator, then one cycle to sample mac_acc.
                    if (drain_cnt == DRN_W'(PIPE_LAT)) begin
                        bus.res_data  <= bus.mac_acc;
                        bus.res_valid <= 1'b1;
                        if (bus.mac_acc == NAN_PAT) begin
                            bus.err <= 1'b1;
                        end
                        state <= S_RESULT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abort wins over the normal transition of an active job.
            if (abort_req && job_active) begin
                state         <= S_IDLE;
                bus.busy      <= 1'b0;
                bus.op_ready  <= 1'b0;
                bus.err       <= 1'b0;
                bus.mac_clr   <= 1'b1;
                bus.mac_a     <= '0;
                bus.mac_b     <= '0;
                bus.res_valid <= 1'b0;
                pair_cnt      <= '0;
                drain_cnt     <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dlfloat_mac_ctrl.sv
// Bench for dlfloat_mac_ctrl: a behavioural DLFloat16 MAC hangs on the
// MAC port, jobs are issued from tasks, and a monitor checks results
// against a scoreboard filled from a real-number dot-product model.
module tb_dlfloat_mac_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef DLMAC_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [2:0] state_dbg;

    dlfloat_mac_ctrl_if #(.LEN_W(8)) bus ();

    dlfloat_mac_ctrl #(.LEN_W(8), .PIPE_LAT(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DLMAC_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int clr_seen = 0;
    int rr_mode  = 0;   // 0 random res_ready, 1 always ready, 2 never ready

    logic [16:0] exp_q[$];
    int          lat_lo_q[$];
    int          lat_hi_q[$];

    logic [15:0] ja[256];
    logic [15:0] jb[256];
    logic [15:0] vals[6] = '{16'h3E00, 16'h4000, 16'h3C00, 16'h3F00, 16'hBE00, 16'h4100};

    // ---------------- DLFloat16 reference arithmetic ----------------
    function automatic real dec(input logic [15:0] h);
        int  e;
        real m;
        e = int'(h[14:9]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(h[8:0]) / 512.0) * (2.0 ** real'(e - 31));
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] enc(input real r);
        real  a;
        int   e;
        int   m;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 31;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e <= 0) return 16'h0000;
        if (e > 62) begin e = 62; a = 1.5; end
        m = $rtoi((a - 1.0) * 512.0);
        return {s, 6'(e), 9'(m)};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        return enc(dec(x) * dec(y));
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        return enc(dec(x) + dec(y));
    endfunction

    // Behavioural MAC: product register then accumulator register. It is
    // deliberately not reset so only mac_clr can discard stale sums.
    logic [15:0] prod_r = 16'h0;
    logic [15:0] acc_r  = 16'h0;
    always @(posedge clk) begin
        prod_r <= fmul(bus.mac_a, bus.mac_b);
        acc_r  <= bus.mac_clr ? 16'h0 : fadd(acc_r, prod_r);
    end
    assign bus.mac_acc = acc_r;

    // ---------------- common helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 500) begin step(); g++; end
        if (bus.busy) begin
            n_checks++; n_err++;
            $display("FAIL idle_timeout: busy=1 expected 0");
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_op_ready"},  bus.op_ready,  0);
        check({tag, "_mac_a"},     bus.mac_a,     0);
        check({tag, "_mac_b"},     bus.mac_b,     0);
        check({tag, "_mac_clr"},   bus.mac_clr,   0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_res_data"},  bus.res_data,  0);
        check({tag, "_err"},       bus.err,       0);
    endtask

    // res_ready driver
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            step();
            bus.res_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
        end
    end

    // ---------------- driver tasks ----------------
    // vmode: 0 random op_valid with vprob %, 1 continuous, 2 pattern 1,0,0,1,...
    task automatic feed(input int l, input int vmode, input int vprob);
        int i = 0;
        int k = 0;
        int g = 0;
        bit v;
        while (i < l && g < 2000) begin
            case (vmode)
                1:       v = 1'b1;
                2:       v = (k % 3 == 0);
                default: v = ($urandom_range(0, 99) < vprob);
            endcase
            bus.op_valid = v;
            bus.op_a     = v ? ja[i] : 16'($urandom);
            bus.op_b     = v ? jb[i] : 16'($urandom);
            if (v && bus.op_ready) i++;
            if (bus.op_ready) k++;
            step();
            g++;
        end
        bus.op_valid = 1'b0;
        if (i < l) begin
            n_checks++; n_err++;
            $display("FAIL feed_timeout: accepted %0d expected %0d", i, l);
        end
    endtask

    task automatic run_job(input int l, input int vmode, input int vprob, input bit hold_start);
        logic nan;
        real  s;
        int   c0;
        int   g;
        bit   saw_rdy;
        wait_idle();
        nan = 1'b0;
        s   = 0.0;
        for (int j = 0; j < l; j++) begin
            if (ja[j] == 16'hFFFF || jb[j] == 16'hFFFF) nan = 1'b1;
            else s = s + dec(ja[j]) * dec(jb[j]);
        end
        exp_q.push_back({nan, nan ? 16'hFFFF : enc(s)});
        c0 = cyc;
        if (l == 0) begin
            lat_lo_q.push_back(c0 + 1); lat_hi_q.push_back(c0 + 2);
        end else if (vmode == 1) begin
            lat_lo_q.push_back(c0 + l + 5); lat_hi_q.push_back(c0 + l + 5);
        end else begin
            lat_lo_q.push_back(-1); lat_hi_q.push_back(-1);
        end
        clr_seen  = 0;
        bus.start = 1'b1;
        bus.len   = 8'(l);
        step();
        bus.start = 1'b0;
        bus.len   = 8'($urandom);
        feed(l, vmode, vprob);
        // Garbage operands after the last pair must never reach the MAC.
        saw_rdy = 1'b0;
        g = 0;
        while (bus.busy && g < 300) begin
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op_a     = 16'($urandom);
            bus.op_b     = 16'($urandom);
            if (bus.op_ready) saw_rdy = 1'b1;
            if (hold_start && bus.res_valid) begin
                bus.start = 1'b1;
                bus.len   = 8'd1;
                rr_mode   = 1;
            end
            step();
            g++;
        end
        bus.op_valid = 1'b0;
        bus.start    = 1'b0;
        if (bus.busy) begin
            n_checks++; n_err++;
            $display("FAIL job_timeout: busy=1 expected 0 (len %0d)", l);
        end
        check("mac_clr_pulses", clr_seen, (l > 0) ? 1 : 0);
        if (l == 0) check("len0_no_op_ready", saw_rdy, 0);
    endtask

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 24) == 0) return 16'hFFFF;
        return vals[$urandom_range(0, 5)];
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        rv_prev = 1'b0;
    logic [16:0] held    = '0;
    always @(negedge clk) begin
        if (rst) begin
            rv_prev = 1'b0;
        end else begin
            if (bus.mac_clr) begin
                clr_seen++;
                check("clr_operands_zero", {bus.mac_a, bus.mac_b}, 32'h0);
            end
            if (bus.res_valid && !rv_prev) begin
                int lo;
                int hi;
                held = {bus.err, bus.res_data};
                if (lat_lo_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_res_valid: got res_valid=1 expected 0");
                end else begin
                    lo = lat_lo_q.pop_front();
                    hi = lat_hi_q.pop_front();
                    if (lo >= 0 && lo == hi) check("res_latency", cyc, lo);
                    else if (lo >= 0) check("res_latency_window", 32'(cyc >= lo && cyc <= hi), 1);
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                logic [16:0] e;
                check("res_stable", {bus.err, bus.res_data}, held);
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", bus.res_data, e[15:0]);
                    check("res_err",  bus.err,      e[16]);
                end
            end
            rv_prev = bus.res_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit saw;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();

        // len=3, three 1.0*1.0 products, continuous valid
        for (int j = 0; j < 3; j++) begin ja[j] = 16'h3E00; jb[j] = 16'h3E00; end
        run_job(3, 1, 100, 0);
        check("t1_res_data_3p0", bus.res_data, 16'h4100);

        // len=2, valid toggling 1,0,0,1 with 1.0*2.0 pairs
        for (int j = 0; j < 2; j++) begin ja[j] = 16'h3E00; jb[j] = 16'h4000; end
        run_job(2, 2, 100, 0);

        // len=0 goes straight to a zero result
        run_job(0, 1, 100, 0);
        check("len0_res_data", bus.res_data, 16'h0000);

        // NaN operand sets err; next finite job clears it
        ja[0] = 16'hFFFF; jb[0] = 16'h3E00;
        ja[1] = 16'h3E00; jb[1] = 16'h3E00;
        run_job(2, 1, 100, 0);
        check("nan_err_held", bus.err, 1);
        ja[0] = 16'h4000; jb[0] = 16'h3F00;
        run_job(1, 0, 60, 0);
        check("err_cleared", bus.err, 0);

        // reset mid-FEED after 1 of 4 pairs
        wait_idle();
        for (int j = 0; j < 4; j++) begin ja[j] = 16'h3E00; jb[j] = 16'h3E00; end
        bus.start = 1'b1; bus.len = 8'd4;
        step();
        bus.start = 1'b0;
        feed(1, 1, 100);
        bus.op_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.op_valid = 1'b0;
        check_outputs_zero("midjob_reset");
        ja[0] = 16'h4000; jb[0] = 16'h4000;
        run_job(1, 1, 100, 0);
        check("post_reset_res_4p0", bus.res_data, 16'h4200);

        // start held through RESULT handshake must be ignored
        rr_mode = 2;
        ja[0] = 16'h3F00; jb[0] = 16'h4000;
        run_job(1, 1, 100, 1);
        saw = 1'b0;
        repeat (4) begin step(); if (bus.busy) saw = 1'b1; end
        check("start_in_result_ignored", saw, 0);
        rr_mode = 0;

`ifdef DLMAC_CTRL_ABORT_EN
        // abort during DRAIN: clear pulse, back to IDLE, no result
        wait_idle();
        clr_seen = 0;
        ja[0] = 16'h4000; jb[0] = 16'h4000;
        ja[1] = 16'h4000; jb[1] = 16'h4000;
        bus.start = 1'b1; bus.len = 8'd2;
        step();
        bus.start = 1'b0;
        feed(2, 1, 100);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_mac_clr",   bus.mac_clr,   1);
        check("abort_busy",      bus.busy,      0);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_err",       bus.err,       0);
        saw = 1'b0;
        repeat (8) begin step(); if (bus.res_valid) saw = 1'b1; end
        check("abort_no_result", saw, 0);
        check("abort_clr_pulses", clr_seen, 2);
`endif

        // randomized jobs
        for (int n = 0; n < 24; n++) begin
            int l;
            l = $urandom_range(0, 6);
            for (int j = 0; j < l; j++) begin ja[j] = pick(); jb[j] = pick(); end
            run_job(l, $urandom_range(0, 1), $urandom_range(30, 100), 0);
        end

        wait_idle();
        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // hard stop if anything above stalls beyond every bounded wait
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
